// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the pattern transmitter: default sizes and the
// transmitter FSM state encoding.
package pattern_tx_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/pattern_tx_shreg.sv
// Loadable MSB-first shift register for the pattern transmitter.
// The pattern is left-aligned on load so the current bit is always the top
// bit of the working register; zeros shift in behind it, so once the last
// bit has gone out the serial output naturally reads 0. A stored copy of the
// pattern and its length lets the top level restart a repetition.
module pattern_tx_shreg
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             reload,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             x,
    output logic             last_bit
);

    logic [WIDTH-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [WIDTH-1:0] data_q;
    logic [LEN_W-1:0] cnt_q;

    // Working register, bit counter and stored copy; clear wins over load,
    // load over reload, reload over shift.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pat_q  <= '0;
            len_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            pat_q  <= pattern;
            len_q  <= len;
            data_q <= pattern << (LEN_W'(WIDTH) - len);
            cnt_q  <= len;
        end else if (reload) begin
            data_q <= pat_q << (LEN_W'(WIDTH) - len_q);
            cnt_q  <= len_q;
        end else if (shift && (cnt_q != '0)) begin
            data_q <= data_q << 1;
            cnt_q  <= cnt_q - LEN_W'(1);
        end
    end

    assign x        = data_q[WIDTH-1];
    assign last_bit = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/pattern_tx.sv
// Pattern transmitter: serialises a captured pattern MSB-first, repeating it
// repeat_cnt+1 times with an optional idle gap between repetitions, and
// pulses done after the final bit. All outputs come straight from flops.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       pattern,
    input  logic [$clog2(WIDTH):0] len,
    input  logic [CNT_W-1:0]       repeat_cnt,
    input  logic [CNT_W-1:0]       gap,
    input  logic                   abort,
    output logic                   x,
    output logic                   x_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int LEN_W = $clog2(WIDTH) + 1;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0] rep_q;
    logic [CNT_W-1:0] gap_cfg_q;
    logic [CNT_W-1:0] gap_left_q;
    logic [LEN_W-1:0] len_c;
    logic             accept;
    logic             last_bit;
    logic             sr_load;
    logic             sr_reload;
    logic             sr_shift;
    logic             sr_clear;
    logic             rep_step;
    logic             x_valid_d;
    logic             busy_d;
    logic             done_d;

    assign len_c  = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    assign accept = start && !abort && (len != '0) &&
                    ((state_q == IDLE) || (state_q == DONE));

    pattern_tx_shreg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sr_load),
        .reload   (sr_reload),
        .shift    (sr_shift),
        .clear    (sr_clear),
        .pattern  (pattern),
        .len      (len_c),
        .x        (x),
        .last_bit (last_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort always returns to IDLE without passing DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = accept ? SHIFT : IDLE;
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_bit) begin
                    if (rep_q != '0) begin
                        state_d = (gap_cfg_q != '0) ? GAP : SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_left_q <= CNT_W'(1)) begin
                    state_d = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath-control decode, looking at the upcoming state so
    // the registered flags line up with the bit the shift register presents.
    always_comb begin
        x_valid_d = (state_d == SHIFT);
        busy_d    = (state_d == SHIFT) || (state_d == GAP);
        done_d    = (state_d == DONE);
        sr_load   = accept;
        sr_reload = (state_d == SHIFT) &&
                    (((state_q == SHIFT) && last_bit) || (state_q == GAP));
        sr_shift  = (state_q == SHIFT) && !sr_reload && (state_d != IDLE);
        sr_clear  = (state_d == IDLE);
        rep_step  = (state_q == SHIFT) && last_bit &&
                    ((state_d == SHIFT) || (state_d == GAP));
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            x_valid <= x_valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Repetition counter counts down remaining repeats; gap counter counts
    // down the idle cycles of the current gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q      <= '0;
            gap_cfg_q  <= '0;
            gap_left_q <= '0;
        end else if (accept) begin
            rep_q      <= repeat_cnt;
            gap_cfg_q  <= gap;
            gap_left_q <= '0;
        end else begin
            if (rep_step) begin
                rep_q <= rep_q - CNT_W'(1);
            end
            if ((state_q == SHIFT) && (state_d == GAP)) begin
                gap_left_q <= gap_cfg_q;
            end else if ((state_q == GAP) && (gap_left_q != '0)) begin
                gap_left_q <= gap_left_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx. Each scenario task drives its own vectors
// and compares {x, x_valid, busy, done} against hand-worked values, one
// cycle at a time, sampling 1 ns after the rising edge.
module tb_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] repeat_cnt;
    logic [3:0] gap;
    logic       abort;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    pattern_tx #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (pattern),
        .len        (len),
        .repeat_cnt (repeat_cnt),
        .gap        (gap),
        .abort      (abort),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Advance one cycle and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start request with the given fields.
    task automatic launch(input logic [7:0] p, input logic [3:0] l,
                          input logic [3:0] r, input logic [3:0] g);
        pattern    = p;
        len        = l;
        repeat_cnt = r;
        gap        = g;
        start      = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst = 1'b1;
        launch(8'hFF, 4'd8, 4'd0, 4'd0);
        abort = 1'b0;
        tick();
        tick();
        exp = 4'b0000;
        checks++;
        if ({x, x_valid, busy, done} !== exp) begin
            failures++;
            $display("[TB] FAIL reset_hold: got %b expected %b", {x, x_valid, busy, done}, exp);
        end
        start = 1'b0;
        rst   = 1'b0;
        tick();
        checks++;
        if ({x, x_valid, busy, done} !== exp) begin
            failures++;
            $display("[TB] FAIL reset_idle: got %b expected %b", {x, x_valid, busy, done}, exp);
        end
    endtask

    task automatic test_single();
        logic [6:0] bits = 7'b1101111;
        logic [3:0] exp;
        launch(8'b0110_1111, 4'd7, 4'd0, 4'd0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = 1'b0;
            if (c <= 7)      exp = {bits[7-c], 3'b110};
            else if (c == 8) exp = 4'b0001;
            else             exp = 4'b0000;
            checks++;
            if ({x, x_valid, busy, done} !== exp) begin
                failures++;
                $display("[TB] FAIL single c%0d: got %b expected %b", c, {x, x_valid, busy, done}, exp);
            end
        end
    endtask

    task automatic test_gap();
        logic [7:0] bits = 8'hA5;
        logic [3:0] exp;
        launch(8'hA5, 4'd8, 4'd1, 4'd2);
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = 1'b0;
            if (c <= 8)       exp = {bits[8-c], 3'b110};
            else if (c <= 10) exp = 4'b0010;
            else if (c <= 18) exp = {bits[18-c], 3'b110};
            else if (c == 19) exp = 4'b0001;
            else              exp = 4'b0000;
            checks++;
            if ({x, x_valid, busy, done} !== exp) begin
                failures++;
                $display("[TB] FAIL gap c%0d: got %b expected %b", c, {x, x_valid, busy, done}, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] bits = 3'b101;
        logic [3:0] exp;
        launch(8'b0000_0101, 4'd3, 4'd2, 4'd0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            if (c <= 9) exp = {bits[2-((c-1)%3)], 3'b110};
            else        exp = 4'b0001;
            checks++;
            if ({x, x_valid, busy, done} !== exp) begin
                failures++;
                $display("[TB] FAIL back_to_back c%0d: got %b expected %b", c, {x, x_valid, busy, done}, exp);
            end
        end
        tick();
    endtask

    task automatic test_abort();
        logic [7:0] bits = 8'hC3;
        logic [7:0] bits2 = 8'h3C;
        logic [3:0] exp;
        launch(8'hC3, 4'd8, 4'd0, 4'd0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            start = 1'b0;
            exp = {bits[8-c], 3'b110};
            checks++;
            if ({x, x_valid, busy, done} !== exp) begin
                failures++;
                $display("[TB] FAIL abort_pre c%0d: got %b expected %b", c, {x, x_valid, busy, done}, exp);
            end
        end
        abort = 1'b1;
        for (int c = 4; c <= 12; c++) begin
            tick();
            abort = 1'b0;
            exp = 4'b0000;
            checks++;
            if ({x, x_valid, busy, done} !== exp) begin
                failures++;
                $display("[TB] FAIL abort_post c%0d: got %b expected %b", c, {x, x_valid, busy, done}, exp);
            end
        end
        launch(8'h3C, 4'd8, 4'd0, 4'd0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = 1'b0;
            if (c <= 8) exp = {bits2[8-c], 3'b110};
            else        exp = 4'b0001;
            checks++;
            if ({x, x_valid, busy, done} !== exp) begin
                failures++;
                $display("[TB] FAIL abort_restart c%0d: got %b expected %b", c, {x, x_valid, busy, done}, exp);
            end
        end
        tick();
    endtask

    task automatic test_ignored();
        logic [7:0] bits = 8'hF0;
        logic [3:0] exp;
        // len = 0 request
        launch(8'hFF, 4'd0, 4'd0, 4'd0);
        for (int c = 1; c <= 2; c++) begin
            tick();
            exp = 4'b0000;
            checks++;
            if ({x, x_valid, busy, done} !== exp) begin
                failures++;
                $display("[TB] FAIL len0 c%0d: got %b expected %b", c, {x, x_valid, busy, done}, exp);
            end
        end
        // start together with abort
        launch(8'hFF, 4'd8, 4'd0, 4'd0);
        abort = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            exp = 4'b0000;
            checks++;
            if ({x, x_valid, busy, done} !== exp) begin
                failures++;
                $display("[TB] FAIL start_abort c%0d: got %b expected %b", c, {x, x_valid, busy, done}, exp);
            end
        end
        abort = 1'b0;
        start = 1'b0;
        tick();
        // start while busy, with different fields held for a few cycles
        launch(8'hF0, 4'd8, 4'd0, 4'd0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1)      launch(8'h0F, 4'd4, 4'd3, 4'd5);
            else if (c == 5) start = 1'b0;
            if (c <= 8)      exp = {bits[8-c], 3'b110};
            else if (c == 9) exp = 4'b0001;
            else             exp = 4'b0000;
            checks++;
            if ({x, x_valid, busy, done} !== exp) begin
                failures++;
                $display("[TB] FAIL start_busy c%0d: got %b expected %b", c, {x, x_valid, busy, done}, exp);
            end
        end
    endtask

    task automatic test_clip();
        logic [7:0] bits = 8'h81;
        logic [3:0] exp;
        launch(8'h81, 4'd12, 4'd0, 4'd0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            if (c <= 8)      exp = {bits[8-c], 3'b110};
            else if (c == 9) exp = 4'b0001;
            else             exp = 4'b0000;
            checks++;
            if ({x, x_valid, busy, done} !== exp) begin
                failures++;
                $display("[TB] FAIL clip c%0d: got %b expected %b", c, {x, x_valid, busy, done}, exp);
            end
        end
    endtask

    task automatic test_max_repeat();
        logic [3:0] exp;
        launch(8'h01, 4'd1, 4'd15, 4'd0);
        for (int c = 1; c <= 18; c++) begin
            tick();
            start = 1'b0;
            if (c <= 16)      exp = 4'b1110;
            else if (c == 17) exp = 4'b0001;
            else              exp = 4'b0000;
            checks++;
            if ({x, x_valid, busy, done} !== exp) begin
                failures++;
                $display("[TB] FAIL max_repeat c%0d: got %b expected %b", c, {x, x_valid, busy, done}, exp);
            end
        end
    endtask

    task automatic test_reset_gap();
        logic [7:0] bits = 8'hA5;
        logic [7:0] bits2 = 8'h96;
        logic [3:0] exp;
        launch(8'hA5, 4'd8, 4'd1, 4'd3);
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = 1'b0;
            if (c <= 8) exp = {bits[8-c], 3'b110};
            else        exp = 4'b0010;
            checks++;
            if ({x, x_valid, busy, done} !== exp) begin
                failures++;
                $display("[TB] FAIL rst_gap_pre c%0d: got %b expected %b", c, {x, x_valid, busy, done}, exp);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp = 4'b0000;
        checks++;
        if ({x, x_valid, busy, done} !== exp) begin
            failures++;
            $display("[TB] FAIL rst_gap_clear: got %b expected %b", {x, x_valid, busy, done}, exp);
        end
        launch(8'h96, 4'd8, 4'd0, 4'd0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            if (c <= 8)      exp = {bits2[8-c], 3'b110};
            else if (c == 9) exp = 4'b0001;
            else             exp = 4'b0000;
            checks++;
            if ({x, x_valid, busy, done} !== exp) begin
                failures++;
                $display("[TB] FAIL rst_gap_restart c%0d: got %b expected %b", c, {x, x_valid, busy, done}, exp);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        pattern    = 8'h00;
        len        = 4'd0;
        repeat_cnt = 4'd0;
        gap        = 4'd0;
        test_reset();
        test_single();
        test_gap();
        test_back_to_back();
        test_abort();
        test_ignored();
        test_clip();
        test_max_repeat();
        test_reset_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
